// File: rtl/fight_pkg.sv
// Shared types and tuning constants for the round / hit controller.
package fight_pkg;

    localparam int HP_W = 7;

    localparam logic [HP_W-1:0] HP_MAX    = 7'd100;
    localparam logic [HP_W-1:0] PUNCH_DMG = 7'd5;
    localparam logic [HP_W-1:0] KICK_DMG  = 7'd8;

    localparam logic [9:0] PUNCH_RANGE = 10'd60;
    localparam logic [9:0] KICK_RANGE  = 10'd70;
    localparam logic [9:0] Y_RANGE     = 10'd50;

    localparam logic [4:0] REACT_FRAMES    = 5'd12;
    localparam logic [4:0] COOLDOWN_FRAMES = 5'd20;

    localparam logic [7:0] COUNTDOWN_FRAMES = 8'd180;
    localparam logic [7:0] KO_FRAMES        = 8'd120;

    localparam logic [1:0] ROUNDS_TO_WIN = 2'd2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COUNTDOWN = 3'd1,
        FIGHT     = 3'd2,
        KO        = 3'd3,
        OVER      = 3'd4
    } phase_t;

    typedef enum logic [1:0] {
        BACK_NONE  = 2'd0,
        BACK_EVADE = 2'd1,
        BACK_KNOCK = 2'd2
    } back_t;

    // Distance between two screen coordinates, always non-negative.
    function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // HP subtract that stops at zero instead of wrapping.
    function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] a, input logic [HP_W-1:0] b);
        return (a > b) ? (a - b) : '0;
    endfunction

endpackage

// File: rtl/fighter_hit_tracker.sv
// Per-fighter bookkeeping: attack edge qualification as attacker, and
// HP / hit-reaction state as defender.
module fighter_hit_tracker
    import fight_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            atk_en,
    input  logic            fight,
    input  logic            kick,
    input  logic            hit_evade,
    input  logic            hit_knock,
    input  logic [HP_W-1:0] hit_dmg,
    output logic            atk_fire,
    output logic            atk_kick,
    output logic [HP_W-1:0] hp,
    output back_t           back
);

    logic       fight_d;
    logic       kick_d;
    logic [4:0] cooldown;
    logic [4:0] react;
    logic       fight_rise;

    assign fight_rise = fight & ~fight_d;
    // A kick edge takes precedence over a punch edge on the same frame.
    assign atk_kick   = kick & ~kick_d;
    // A stunned or recovering attacker cannot start a new attack.
    assign atk_fire   = atk_en && (fight_rise || atk_kick) &&
                        (cooldown == 5'd0) && (back == BACK_NONE);

    // Previous-frame action flags for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fight_d <= 1'b0;
            kick_d  <= 1'b0;
        end else begin
            fight_d <= fight;
            kick_d  <= kick;
        end
    end

    // Attack cooldown: reloaded on every accepted attack, hit or miss.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cooldown <= 5'd0;
        end else if (clear) begin
            cooldown <= 5'd0;
        end else if (atk_fire) begin
            cooldown <= COOLDOWN_FRAMES;
        end else if (cooldown != 5'd0) begin
            cooldown <= cooldown - 5'd1;
        end
    end

    // Defender side: reaction code, its hold timer, and HP loss.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hp    <= HP_MAX;
            back  <= BACK_NONE;
            react <= 5'd0;
        end else if (clear) begin
            hp    <= HP_MAX;
            back  <= BACK_NONE;
            react <= 5'd0;
        end else if (hit_evade || hit_knock) begin
            back  <= hit_knock ? BACK_KNOCK : BACK_EVADE;
            react <= REACT_FRAMES;
            if (hit_knock) begin
                hp <= sat_sub(hp, hit_dmg);
            end
        end else if (react != 5'd0) begin
            react <= react - 5'd1;
            if (react == 5'd1) begin
                back <= BACK_NONE;
            end
        end
    end

endmodule

// File: rtl/round_hit_ctrl.sv
// Match/round sequencer and hit arbiter for the two fighters.
module round_hit_ctrl
    import fight_pkg::*;
(
    input  logic       frame_clk,
    input  logic       Reset_n,
    input  logic       start,
    input  logic [9:0] BallX1,
    input  logic [9:0] BallY1,
    input  logic [9:0] BallX,
    input  logic [9:0] BallY,
    input  logic       fight_1,
    input  logic       kick_1,
    input  logic       jump_1,
    input  logic       dodge_1,
    input  logic       fight_2,
    input  logic       kick_2,
    input  logic       jump_2,
    input  logic       dodge_2,
    output logic       st,
    output logic       p1win,
    output logic       p2win,
    output logic [1:0] back1,
    output logic [1:0] back2,
    output logic [6:0] hp1,
    output logic [6:0] hp2,
    output logic [1:0] wins1,
    output logic [1:0] wins2,
    output logic [2:0] phase
);

    phase_t     state;
    logic [7:0] timer;
    logic       start_d;
    logic       start_rise;
    logic       match_over;
    logic       clear_round;
    logic       atk_en;
    logic [9:0] dx;
    logic [9:0] dy;
    logic       fire1, kick1_atk, fire2, kick2_atk;
    logic       land1, land2;
    logic       evade1, evade2;
    back_t      bk1, bk2;

    assign start_rise = start & ~start_d;
    assign match_over = (wins1 == ROUNDS_TO_WIN) || (wins2 == ROUNDS_TO_WIN);
    // Every path into COUNTDOWN starts a fresh round.
    assign clear_round = (((state == IDLE) || (state == OVER)) && start_rise) ||
                         ((state == KO) && (timer == KO_FRAMES - 8'd1) && !match_over);
    // Once someone is at zero the round is decided; no further attacks count.
    assign atk_en = (state == FIGHT) && (hp1 != 7'd0) && (hp2 != 7'd0);

    assign dx = abs_diff(BallX1, BallX);
    assign dy = abs_diff(BallY1, BallY);

    assign land1  = fire1 && (dy <= Y_RANGE) && (dx <= (kick1_atk ? KICK_RANGE : PUNCH_RANGE));
    assign land2  = fire2 && (dy <= Y_RANGE) && (dx <= (kick2_atk ? KICK_RANGE : PUNCH_RANGE));
    assign evade1 = jump_1 | dodge_1;
    assign evade2 = jump_2 | dodge_2;

    assign back1 = bk1;
    assign back2 = bk2;
    assign phase = state;

    fighter_hit_tracker u_p1 (
        .clk       (frame_clk),
        .rst_n     (Reset_n),
        .clear     (clear_round),
        .atk_en    (atk_en),
        .fight     (fight_1),
        .kick      (kick_1),
        .hit_evade (land2 & evade1),
        .hit_knock (land2 & ~evade1),
        .hit_dmg   (kick2_atk ? KICK_DMG : PUNCH_DMG),
        .atk_fire  (fire1),
        .atk_kick  (kick1_atk),
        .hp        (hp1),
        .back      (bk1)
    );

    fighter_hit_tracker u_p2 (
        .clk       (frame_clk),
        .rst_n     (Reset_n),
        .clear     (clear_round),
        .atk_en    (atk_en),
        .fight     (fight_2),
        .kick      (kick_2),
        .hit_evade (land1 & evade2),
        .hit_knock (land1 & ~evade2),
        .hit_dmg   (kick1_atk ? KICK_DMG : PUNCH_DMG),
        .atk_fire  (fire2),
        .atk_kick  (kick2_atk),
        .hp        (hp2),
        .back      (bk2)
    );

    // Phase FSM with registered play enable, winner flags and win counters.
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= IDLE;
            timer   <= 8'd0;
            start_d <= 1'b0;
            st      <= 1'b0;
            p1win   <= 1'b0;
            p2win   <= 1'b0;
            wins1   <= 2'd0;
            wins2   <= 2'd0;
        end else begin
            start_d <= start;
            case (state)
                IDLE: begin
                    if (start_rise) begin
                        state <= COUNTDOWN;
                        timer <= 8'd0;
                    end
                end
                COUNTDOWN: begin
                    if (timer == COUNTDOWN_FRAMES - 8'd1) begin
                        state <= FIGHT;
                        timer <= 8'd0;
                        st    <= 1'b1;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                FIGHT: begin
                    if ((hp1 == 7'd0) || (hp2 == 7'd0)) begin
                        state <= KO;
                        timer <= 8'd0;
                        st    <= 1'b0;
                        // A double KO awards nothing and the round is replayed.
                        p1win <= (hp2 == 7'd0) && (hp1 != 7'd0);
                        p2win <= (hp1 == 7'd0) && (hp2 != 7'd0);
                        if ((hp2 == 7'd0) && (hp1 != 7'd0) && (wins1 != ROUNDS_TO_WIN)) begin
                            wins1 <= wins1 + 2'd1;
                        end
                        if ((hp1 == 7'd0) && (hp2 != 7'd0) && (wins2 != ROUNDS_TO_WIN)) begin
                            wins2 <= wins2 + 2'd1;
                        end
                    end
                end
                KO: begin
                    if (timer == KO_FRAMES - 8'd1) begin
                        timer <= 8'd0;
                        if (match_over) begin
                            state <= OVER;
                        end else begin
                            state <= COUNTDOWN;
                            p1win <= 1'b0;
                            p2win <= 1'b0;
                        end
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                OVER: begin
                    if (start_rise) begin
                        state <= COUNTDOWN;
                        timer <= 8'd0;
                        p1win <= 1'b0;
                        p2win <= 1'b0;
                        wins1 <= 2'd0;
                        wins2 <= 2'd0;
                    end
                end
                default: begin
                    state <= IDLE;
                    timer <= 8'd0;
                    st    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_round_hit_ctrl.sv
// Bench for round_hit_ctrl: directed sequences with hand-derived values plus
// randomized play checked against a frame-level game model.
module tb_round_hit_ctrl;

    logic       frame_clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       start = 1'b0;
    logic [9:0] BallX1 = 10'd300, BallY1 = 10'd200, BallX = 10'd350, BallY = 10'd200;
    logic       fight_1 = 0, kick_1 = 0, jump_1 = 0, dodge_1 = 0;
    logic       fight_2 = 0, kick_2 = 0, jump_2 = 0, dodge_2 = 0;
    logic       st, p1win, p2win;
    logic [1:0] back1, back2, wins1, wins2;
    logic [6:0] hp1, hp2;
    logic [2:0] phase;

    round_hit_ctrl dut (
        .frame_clk(frame_clk), .Reset_n(Reset_n), .start(start),
        .BallX1(BallX1), .BallY1(BallY1), .BallX(BallX), .BallY(BallY),
        .fight_1(fight_1), .kick_1(kick_1), .jump_1(jump_1), .dodge_1(dodge_1),
        .fight_2(fight_2), .kick_2(kick_2), .jump_2(jump_2), .dodge_2(dodge_2),
        .st(st), .p1win(p1win), .p2win(p2win), .back1(back1), .back2(back2),
        .hp1(hp1), .hp2(hp2), .wins1(wins1), .wins2(wins2), .phase(phase)
    );

    always #5 frame_clk = ~frame_clk;

    int nvec = 0;
    int nmis = 0;

    // Game model: phase 0 idle,1 countdown,2 fight,3 ko,4 over.
    int m_phase, m_left, m_st;
    int m_hp[2], m_back[2], m_react[2], m_cd[2], m_wins[2], m_win[2];
    int m_pf[2], m_pk[2], m_ps;

    typedef struct {
        int    x2, y2, f1, k1, k2, d2;
        int    ehp1, ehp2, eb2, wait_n;
        string nm;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nmis++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_left = 0; m_st = 0; m_ps = 0;
        for (int p = 0; p < 2; p++) begin
            m_hp[p] = 100; m_back[p] = 0; m_react[p] = 0; m_cd[p] = 0;
            m_wins[p] = 0; m_win[p] = 0; m_pf[p] = 0; m_pk[p] = 0;
        end
    endtask

    task automatic model_step();
        int f[2], k[2], ev[2], x[2], y[2], old_hp[2], fire[2], kk[2];
        int rs, new_round, ddx, ddy, reach, landed, a;
        f[0] = fight_1; f[1] = fight_2; k[0] = kick_1; k[1] = kick_2;
        ev[0] = int'(jump_1 | dodge_1); ev[1] = int'(jump_2 | dodge_2);
        x[0] = int'(BallX1); x[1] = int'(BallX); y[0] = int'(BallY1); y[1] = int'(BallY);
        rs = (start && !m_ps) ? 1 : 0;
        new_round = 0;
        for (int p = 0; p < 2; p++) begin
            old_hp[p] = m_hp[p];
            kk[p] = (k[p] && !m_pk[p]) ? 1 : 0;
            fire[p] = (m_phase == 2 && m_hp[0] > 0 && m_hp[1] > 0 &&
                       ((f[p] && !m_pf[p]) || kk[p] == 1) &&
                       m_cd[p] == 0 && m_back[p] == 0) ? 1 : 0;
        end
        for (int p = 0; p < 2; p++) begin
            if (fire[p] == 1) m_cd[p] = 20;
            else if (m_cd[p] > 0) m_cd[p]--;
        end
        ddx = (x[0] > x[1]) ? x[0] - x[1] : x[1] - x[0];
        ddy = (y[0] > y[1]) ? y[0] - y[1] : y[1] - y[0];
        for (int d = 0; d < 2; d++) begin
            a = 1 - d;
            reach = (kk[a] == 1) ? 70 : 60;
            landed = (fire[a] == 1 && ddx <= reach && ddy <= 50) ? 1 : 0;
            if (landed == 1) begin
                m_react[d] = 12;
                if (ev[d] != 0) m_back[d] = 1;
                else begin
                    m_back[d] = 2;
                    m_hp[d] = m_hp[d] - ((kk[a] == 1) ? 8 : 5);
                    if (m_hp[d] < 0) m_hp[d] = 0;
                end
            end else if (m_react[d] > 0) begin
                m_react[d]--;
                if (m_react[d] == 0) m_back[d] = 0;
            end
        end
        case (m_phase)
            0: if (rs == 1) new_round = 1;
            1: begin
                m_left--;
                if (m_left == 0) begin m_phase = 2; m_st = 1; end
            end
            2: if (old_hp[0] == 0 || old_hp[1] == 0) begin
                m_phase = 3; m_st = 0; m_left = 120;
                m_win[0] = (old_hp[1] == 0 && old_hp[0] != 0) ? 1 : 0;
                m_win[1] = (old_hp[0] == 0 && old_hp[1] != 0) ? 1 : 0;
                for (int p = 0; p < 2; p++)
                    if (m_win[p] == 1 && m_wins[p] < 2) m_wins[p]++;
            end
            3: begin
                m_left--;
                if (m_left == 0) begin
                    if (m_wins[0] == 2 || m_wins[1] == 2) m_phase = 4;
                    else new_round = 1;
                end
            end
            4: if (rs == 1) begin
                m_wins[0] = 0; m_wins[1] = 0; new_round = 1;
            end
            default: ;
        endcase
        if (new_round == 1) begin
            m_phase = 1; m_left = 180;
            for (int p = 0; p < 2; p++) begin
                m_hp[p] = 100; m_back[p] = 0; m_react[p] = 0; m_cd[p] = 0; m_win[p] = 0;
            end
        end
        m_pf[0] = f[0]; m_pf[1] = f[1]; m_pk[0] = k[0]; m_pk[1] = k[1]; m_ps = start;
    endtask

    task automatic compare_all();
        chk("phase", int'(phase), m_phase);
        chk("st", int'(st), m_st);
        chk("p1win", int'(p1win), m_win[0]);
        chk("p2win", int'(p2win), m_win[1]);
        chk("hp1", int'(hp1), m_hp[0]);
        chk("hp2", int'(hp2), m_hp[1]);
        chk("back1", int'(back1), m_back[0]);
        chk("back2", int'(back2), m_back[1]);
        chk("wins1", int'(wins1), m_wins[0]);
        chk("wins2", int'(wins2), m_wins[1]);
    endtask

    task automatic frame();
        @(posedge frame_clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    initial begin
        int exp1, exp2;

        // Reset state
        model_reset();
        #12;
        compare_all();
        chk("rst_phase", int'(phase), 0);
        chk("rst_hp1", int'(hp1), 100);
        Reset_n = 1'b1;

        // Start, countdown length, fight entry
        start = 1'b1; frame(); start = 1'b0;
        chk("cd_enter", int'(phase), 1);
        run(179);
        chk("cd_st", int'(st), 0);
        chk("cd_hold", int'(phase), 1);
        frame();
        chk("fight_enter", int'(phase), 2);
        chk("fight_st", int'(st), 1);
        chk("fight_hp2", int'(hp2), 100);

        // Landed kick and the 12-frame knockback hold
        kick_1 = 1'b1; frame(); kick_1 = 1'b0;
        chk("kick_hp2", int'(hp2), 92);
        chk("kick_back2", int'(back2), 2);
        run(11);
        chk("back2_hold", int'(back2), 2);
        frame();
        chk("back2_clear", int'(back2), 0);
        run(15);

        // Single-frame contact vectors
        tbl[0] = '{350, 200, 1, 0, 0, 1, 100, 92, 1, 25, "dodge"};
        tbl[1] = '{365, 200, 1, 0, 0, 0, 100, 92, 0,  4, "miss"};
        tbl[2] = '{350, 200, 1, 0, 0, 0, 100, 92, 0, 25, "cooldown"};
        tbl[3] = '{340, 200, 0, 1, 1, 0,  92, 84, 2, 25, "trade"};
        tbl[4] = '{350, 251, 0, 1, 0, 0,  92, 84, 0, 25, "y_out"};
        tbl[5] = '{370, 250, 0, 1, 0, 0,  92, 76, 2, 25, "reach_edge"};
        for (int i = 0; i < 6; i++) begin
            BallX = 10'(tbl[i].x2); BallY = 10'(tbl[i].y2);
            fight_1 = tbl[i].f1[0]; kick_1 = tbl[i].k1[0];
            kick_2 = tbl[i].k2[0]; dodge_2 = tbl[i].d2[0];
            frame();
            fight_1 = 0; kick_1 = 0; kick_2 = 0; dodge_2 = 0;
            chk({tbl[i].nm, "_hp1"}, int'(hp1), tbl[i].ehp1);
            chk({tbl[i].nm, "_hp2"}, int'(hp2), tbl[i].ehp2);
            chk({tbl[i].nm, "_back2"}, int'(back2), tbl[i].eb2);
            run(tbl[i].wait_n);
        end
        BallX = 10'd350; BallY = 10'd200;

        // Punch P2 down to zero (saturating), KO hold, next round
        exp2 = 76;
        while (exp2 > 0) begin
            fight_1 = 1'b1; frame(); fight_1 = 1'b0;
            exp2 = (exp2 > 5) ? exp2 - 5 : 0;
            chk("drain_hp2", int'(hp2), exp2);
            if (exp2 > 0) run(25);
        end
        frame();
        chk("ko_enter", int'(phase), 3);
        chk("ko_p1win", int'(p1win), 1);
        chk("ko_wins1", int'(wins1), 1);
        run(119);
        chk("ko_hold", int'(phase), 3);
        chk("ko_p1win_hold", int'(p1win), 1);
        frame();
        chk("r2_cd", int'(phase), 1);
        chk("r2_hp2", int'(hp2), 100);

        // Second round won by P1 with kicks -> match over
        run(180);
        chk("r2_fight", int'(phase), 2);
        exp2 = 100;
        while (exp2 > 0) begin
            kick_1 = 1'b1; frame(); kick_1 = 1'b0;
            exp2 = (exp2 > 8) ? exp2 - 8 : 0;
            chk("r2_hp2", int'(hp2), exp2);
            if (exp2 > 0) run(25);
        end
        frame();
        chk("r2_wins1", int'(wins1), 2);
        run(119);
        frame();
        chk("over", int'(phase), 4);
        chk("over_p1win", int'(p1win), 1);

        // Restart from OVER, then a double KO replays the round
        start = 1'b1; frame(); start = 1'b0;
        chk("restart_cd", int'(phase), 1);
        chk("restart_wins1", int'(wins1), 0);
        run(180);
        chk("r3_fight", int'(phase), 2);
        BallX = 10'd340;
        exp1 = 100;
        while (exp1 > 0) begin
            kick_1 = 1'b1; kick_2 = 1'b1; frame(); kick_1 = 1'b0; kick_2 = 1'b0;
            exp1 = (exp1 > 8) ? exp1 - 8 : 0;
            chk("dko_hp1", int'(hp1), exp1);
            chk("dko_hp2", int'(hp2), exp1);
            if (exp1 > 0) run(25);
        end
        frame();
        chk("dko_phase", int'(phase), 3);
        chk("dko_p1win", int'(p1win), 0);
        chk("dko_p2win", int'(p2win), 0);
        chk("dko_wins2", int'(wins2), 0);
        run(119);
        frame();
        chk("dko_replay", int'(phase), 1);

        // Asynchronous reset in the middle of a fight
        run(180);
        kick_1 = 1'b1; frame(); kick_1 = 1'b0;
        chk("pre_rst_hp2", int'(hp2), 92);
        run(3);
        #2 Reset_n = 1'b0;
        #1;
        model_reset();
        chk("arst_phase", int'(phase), 0);
        chk("arst_st", int'(st), 0);
        chk("arst_hp2", int'(hp2), 100);
        chk("arst_back2", int'(back2), 0);
        compare_all();
        #2 Reset_n = 1'b1;

        // Randomized play against the model
        for (int i = 0; i < 4000; i++) begin
            start   = ($urandom_range(0, 19) == 0);
            BallX1  = 10'(250 + $urandom_range(0, 99));
            BallX   = 10'(280 + $urandom_range(0, 99));
            BallY1  = 10'(200 + $urandom_range(0, 59));
            BallY   = 10'(200 + $urandom_range(0, 59));
            fight_1 = ($urandom_range(0, 3) == 0);
            kick_1  = ($urandom_range(0, 3) == 0);
            fight_2 = ($urandom_range(0, 3) == 0);
            kick_2  = ($urandom_range(0, 3) == 0);
            jump_1  = ($urandom_range(0, 5) == 0);
            dodge_1 = ($urandom_range(0, 5) == 0);
            jump_2  = ($urandom_range(0, 5) == 0);
            dodge_2 = ($urandom_range(0, 5) == 0);
            frame();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
